// File: rtl/layer0_input_packer_if.sv
// Feature-beat stream in, packed layer-0 vector out.
// The packer is the slave of both halves; the producer and consumer side is the master.
interface layer0_input_packer_if #(
    parameter int N_FEAT  = 49,
    parameter int FEAT_BW = 2
);
    localparam int VEC_W = N_FEAT * FEAT_BW;

    logic               s_valid;
    logic               s_ready;
    logic [FEAT_BW-1:0] s_data;
    logic               s_last;
    logic               m_valid;
    logic               m_ready;
    logic [VEC_W-1:0]   m_data;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/layer0_input_packer.sv
// Packs a stream of quantized features into one vector per sample for layer 0.
// FILL gathers the sample and HOLD presents it; malformed samples are dropped and counted.
module layer0_input_packer #(
    parameter  int N_FEAT  = 49,
    parameter  int FEAT_BW = 2,
    localparam int VEC_W   = N_FEAT * FEAT_BW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    layer0_input_packer_if.slave   bus,
    output logic                   frame_err,
    output logic [15:0]            err_count
);
    localparam int IDX_W = $clog2(N_FEAT + 1);

    typedef enum logic [1:0] {ST_FILL, ST_FULL, ST_DRAIN} state_t;

    state_t                         r_state, w_state_nxt;
    logic                           r_live;
    logic [IDX_W-1:0]               r_idx, w_idx_nxt;
    logic [N_FEAT-1:0][FEAT_BW-1:0] r_fill, w_fill_nxt;
    logic [VEC_W-1:0]               r_hold;
    logic                           r_hold_vld;
    logic                           r_frame_err;
    logic [15:0]                    r_err_count;

    logic w_acc, w_take, w_at_end;
    logic w_fill_we, w_load_hold, w_load_full, w_err;

    // r_live keeps s_ready low while in reset and for the release edge
    assign bus.s_ready = r_live && (r_state != ST_FULL);
    assign bus.m_valid = r_hold_vld;
    assign bus.m_data  = r_hold;
    assign frame_err   = r_frame_err;
    assign err_count   = r_err_count;

    assign w_acc    = bus.s_valid && bus.s_ready;
    assign w_take   = r_hold_vld && bus.m_ready;
    assign w_at_end = (r_idx == IDX_W'(N_FEAT - 1));

    always_comb begin
        w_fill_nxt = r_fill;
        for (int k = 0; k < N_FEAT; k++) begin
            if (r_idx == IDX_W'(k)) w_fill_nxt[k] = bus.s_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_fill_we   = 1'b0;
        w_load_hold = 1'b0;
        w_load_full = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_acc) begin
                    if (bus.s_last && w_at_end) begin
                        w_idx_nxt = '0;
                        w_fill_we = 1'b1;
                        if (!r_hold_vld || bus.m_ready) w_load_hold = 1'b1;
                        else                            w_state_nxt = ST_FULL;
                    end else if (bus.s_last) begin
                        w_idx_nxt = '0;
                        w_err     = 1'b1;
                    end else if (w_at_end) begin
                        w_idx_nxt   = '0;
                        w_err       = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_fill_we = 1'b1;
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            // HOLD is always occupied here, so m_ready alone means it is consumed
            ST_FULL: begin
                if (bus.m_ready) begin
                    w_load_full = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (w_acc && bus.s_last) w_state_nxt = ST_FILL;
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_live  <= 1'b0;
            r_idx   <= '0;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            r_idx   <= w_idx_nxt;
            if (w_fill_we) r_fill <= w_fill_nxt;
        end
    end

    // The completing beat goes straight into HOLD via w_fill_nxt, so no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
        end else if (w_load_hold) begin
            r_hold     <= w_fill_nxt;
            r_hold_vld <= 1'b1;
        end else if (w_load_full) begin
            r_hold     <= r_fill;
            r_hold_vld <= 1'b1;
        end else if (w_take) begin
            r_hold_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_frame_err <= w_err;
            if (w_err && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_layer0_input_packer.sv
// Directed bench for layer0_input_packer with N_FEAT=3, FEAT_BW=2.
module tb_layer0_input_packer;
    localparam int N_FEAT  = 3;
    localparam int FEAT_BW = 2;
    localparam int VEC_W   = N_FEAT * FEAT_BW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_err;
    logic [15:0] err_count;

    layer0_input_packer_if #(.N_FEAT(N_FEAT), .FEAT_BW(FEAT_BW)) bus ();

    layer0_input_packer #(.N_FEAT(N_FEAT), .FEAT_BW(FEAT_BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int n_ferr = 0;
    int n_nordy = 0;
    bit streaming = 1'b0;
    logic [VEC_W-1:0] q[$];
    logic [VEC_W-1:0] exp_q[$];

    // inputs change at posedge+1, so a negedge sample sees the next transfer
    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready) q.push_back(bus.m_data);
        if (frame_err) n_ferr++;
        if (streaming && !bus.s_ready) n_nordy++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [FEAT_BW-1:0] d, input logic l);
        bit ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("beat_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic sample3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        beat(a, 1'b0);
        beat(b, 1'b0);
        beat(c, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_mvalid"}, {31'd0, bus.m_valid}, 32'd0);
        check({tag, "_mdata"},  {26'd0, bus.m_data},  32'd0);
        check({tag, "_sready"}, {31'd0, bus.s_ready}, 32'd0);
        check({tag, "_ferr"},   {31'd0, frame_err},   32'd0);
        check({tag, "_errcnt"}, {16'd0, err_count},   32'd0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_release_sready", {31'd0, bus.s_ready}, 32'd1);
        idle(1);

        // basic pack, 1-cycle latency, single-cycle m_valid
        bus.m_ready = 1'b1;
        q.delete();
        sample3(2'b01, 2'b10, 2'b11);
        @(negedge clk);
        check("basic_mvalid", {31'd0, bus.m_valid}, 32'd1);
        check("basic_mdata", {26'd0, bus.m_data}, 32'h39);
        @(negedge clk);
        check("basic_mvalid_drop", {31'd0, bus.m_valid}, 32'd0);
        check("basic_count", q.size(), 32'd1);
        idle(1);

        // backpressure: two samples, second parks in FILL
        bus.m_ready = 1'b0;
        q.delete();
        sample3(2'd0, 2'd1, 2'd2);
        sample3(2'd3, 2'd0, 2'd1);
        @(negedge clk);
        check("bp_sready_low", {31'd0, bus.s_ready}, 32'd0);
        check("bp_mvalid", {31'd0, bus.m_valid}, 32'd1);
        check("bp_hold_a", {26'd0, bus.m_data}, 32'h24);
        idle(3);
        check("bp_stable", {26'd0, bus.m_data}, 32'h24);
        bus.m_ready = 1'b1;
        idle(4);
        check("bp_count", q.size(), 32'd2);
        if (q.size() == 2) begin
            check("bp_first", {26'd0, q[0]}, 32'h24);
            check("bp_second", {26'd0, q[1]}, 32'h13);
        end
        check("bp_sready_back", {31'd0, bus.s_ready}, 32'd1);

        // early end on beat 2
        q.delete();
        n_ferr = 0;
        beat(2'd1, 1'b0);
        beat(2'd2, 1'b1);
        @(negedge clk);
        check("early_ferr", {31'd0, frame_err}, 32'd1);
        check("early_errcnt", {16'd0, err_count}, 32'd1);
        idle(2);
        check("early_no_mvalid", q.size(), 32'd0);
        sample3(2'd2, 2'd3, 2'd1);
        idle(2);
        check("early_next_count", q.size(), 32'd1);
        if (q.size() == 1) check("early_next_data", {26'd0, q[0]}, 32'h1E);
        check("early_ferr_pulses", n_ferr, 32'd1);

        // missing end: 5 beats, last on 5th
        q.delete();
        n_ferr = 0;
        beat(2'd1, 1'b0);
        beat(2'd1, 1'b0);
        beat(2'd1, 1'b0);
        @(negedge clk);
        check("miss_ferr", {31'd0, frame_err}, 32'd1);
        beat(2'd0, 1'b0);
        beat(2'd2, 1'b1);
        idle(2);
        check("miss_errcnt", {16'd0, err_count}, 32'd2);
        check("miss_ferr_pulses", n_ferr, 32'd1);
        check("miss_dropped", q.size(), 32'd0);
        sample3(2'd3, 2'd3, 2'd0);
        idle(2);
        check("miss_next_count", q.size(), 32'd1);
        if (q.size() == 1) check("miss_next_data", {26'd0, q[0]}, 32'h0F);

        // reset mid-sample
        q.delete();
        beat(2'd3, 1'b0);
        beat(2'd3, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_outs("midrst");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        sample3(2'd1, 2'd0, 2'd2);
        idle(2);
        check("midrst_count", q.size(), 32'd1);
        if (q.size() == 1) check("midrst_data", {26'd0, q[0]}, 32'h21);
        check("midrst_errcnt", {16'd0, err_count}, 32'd0);

        // 100 samples streaming at full rate
        q.delete();
        exp_q.delete();
        n_nordy = 0;
        streaming = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [1:0] f0, f1, f2;
            f0 = 2'(i % 4);
            f1 = 2'((i / 4) % 4);
            f2 = 2'((i / 16) % 4);
            exp_q.push_back({f2, f1, f0});
            sample3(f0, f1, f2);
        end
        streaming = 1'b0;
        idle(3);
        check("stream_count", q.size(), 32'd100);
        check("stream_no_stall", n_nordy, 32'd0);
        if (q.size() == 100) begin
            for (int i = 0; i < 100; i++) check($sformatf("stream_%0d", i), {26'd0, q[i]}, {26'd0, exp_q[i]});
        end
        check("stream_errcnt", {16'd0, err_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
